// File: rtl/psram_qpi_model.sv
// rtl/psram_qpi_model.sv - QSPI/QPI PSRAM device model with internal byte array
`timescale 1ns/1ps

module psram_qpi_model #(
  parameter int MEM_AW    = 16,
  parameter int READ_WAIT = 6,
  parameter int SYNC_STG  = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       sck,
  input  logic       ce_n,
  input  logic [3:0] dio_i,
  output logic [3:0] dio_o,
  output logic       dio_oe,
  output logic       qpi_mode
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_WAIT,
    S_RDATA,
    S_WDATA,
    S_IGNORE
  } state_e;

  // {ce_n, sck, dio} travel together so edges and data stay aligned
  logic [5:0]        sync_q [SYNC_STG];
  logic              sck_prev_q;
  logic              ce_prev_q;
  logic              sck_s;
  logic              ce_s;
  logic [3:0]        dio_s;
  logic              rise_d;
  logic              fall_d;
  logic              ce_fall_d;

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic [19:0]       sr_q;
  logic [MEM_AW-1:0] addr_q;
  logic              is_wr_q;
  logic              rst_en_q;
  logic              qpi_q;
  logic              oe_q;
  logic [3:0]        dout_q;
  logic              lo_next_q;
  logic              wphase_q;
  logic [3:0]        whi_q;
  logic              armed_q;
  logic [7:0]        rd_byte_q;

  logic [7:0]        cmd_d;
  logic              cmd_last_d;
  logic [MEM_AW-1:0] addr_d;
  logic              wr_en_d;

  logic [7:0]        mem [0:(1<<MEM_AW)-1];

  // Oversample the pins and keep one cycle of history for edge detection
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STG; i++) sync_q[i] <= 6'b100000;
      sck_prev_q <= 1'b0;
      ce_prev_q  <= 1'b1;
    end else begin
      sync_q[0] <= {ce_n, sck, dio_i};
      for (int i = 1; i < SYNC_STG; i++) sync_q[i] <= sync_q[i-1];
      sck_prev_q <= sck_s;
      ce_prev_q  <= ce_s;
    end
  end

  assign ce_s      = sync_q[SYNC_STG-1][5];
  assign sck_s     = sync_q[SYNC_STG-1][4];
  assign dio_s     = sync_q[SYNC_STG-1][3:0];
  assign rise_d    = sck_s & ~sck_prev_q & ~ce_s;
  assign fall_d    = ~sck_s & sck_prev_q & ~ce_s;
  assign ce_fall_d = ce_prev_q & ~ce_s;

  // Command byte as it will look after the current rise is shifted in
  assign cmd_d      = qpi_q ? {sr_q[3:0], dio_s} : {sr_q[6:0], dio_s[0]};
  assign cmd_last_d = qpi_q ? (cnt_q == 4'd1) : (cnt_q == 4'd7);
  // Upper address bits beyond the array size are simply dropped
  assign addr_d     = MEM_AW'({sr_q, dio_s});
  assign wr_en_d    = (state_q == S_WDATA) && rise_d && wphase_q;

  // Byte array: write on the low-nibble rise, continuously fetch the current address
  always_ff @(posedge clock) begin
    if (wr_en_d) mem[addr_q] <= {whi_q, dio_s};
    rd_byte_q <= mem[addr_q];
  end

  // Protocol FSM with registered pin outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      sr_q      <= 20'd0;
      addr_q    <= '0;
      is_wr_q   <= 1'b0;
      rst_en_q  <= 1'b0;
      qpi_q     <= 1'b0;
      oe_q      <= 1'b0;
      dout_q    <= 4'd0;
      lo_next_q <= 1'b0;
      wphase_q  <= 1'b0;
      whi_q     <= 4'd0;
      armed_q   <= 1'b0;
    end else if (ce_s) begin
      // Deselect aborts any frame; a half-received write byte is discarded
      state_q  <= S_IDLE;
      oe_q     <= 1'b0;
      wphase_q <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ce_fall_d) begin
            state_q <= S_CMD;
            cnt_q   <= 4'd0;
          end
        end
        S_CMD: begin
          if (rise_d) begin
            sr_q  <= qpi_q ? {sr_q[15:0], dio_s} : {sr_q[18:0], dio_s[0]};
            cnt_q <= cnt_q + 4'd1;
            if (cmd_last_d) begin
              cnt_q    <= 4'd0;
              rst_en_q <= (cmd_d == 8'h66);
              state_q  <= S_IGNORE;
              case (cmd_d)
                8'hEB: begin
                  state_q <= S_ADDR;
                  is_wr_q <= 1'b0;
                end
                8'h38: begin
                  state_q <= S_ADDR;
                  is_wr_q <= 1'b1;
                end
                8'h35: qpi_q <= 1'b1;
                8'hF5: if (qpi_q) qpi_q <= 1'b0;
                8'h99: if (rst_en_q) qpi_q <= 1'b0;
                default: ;
              endcase
            end
          end
        end
        S_ADDR: begin
          if (rise_d) begin
            sr_q  <= {sr_q[15:0], dio_s};
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == 4'd5) begin
              addr_q   <= addr_d;
              cnt_q    <= 4'd0;
              wphase_q <= 1'b0;
              armed_q  <= 1'b0;
              state_q  <= is_wr_q ? S_WDATA : S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (rise_d && !armed_q) begin
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == 4'(READ_WAIT - 1)) armed_q <= 1'b1;
          end
          if (fall_d && armed_q) begin
            oe_q      <= 1'b1;
            dout_q    <= rd_byte_q[7:4];
            lo_next_q <= 1'b1;
            state_q   <= S_RDATA;
          end
        end
        S_RDATA: begin
          if (fall_d) begin
            if (lo_next_q) begin
              dout_q    <= rd_byte_q[3:0];
              addr_q    <= addr_q + MEM_AW'(1);
              lo_next_q <= 1'b0;
            end else begin
              dout_q    <= rd_byte_q[7:4];
              lo_next_q <= 1'b1;
            end
          end
        end
        S_WDATA: begin
          if (rise_d) begin
            if (!wphase_q) begin
              whi_q    <= dio_s;
              wphase_q <= 1'b1;
            end else begin
              addr_q   <= addr_q + MEM_AW'(1);
              wphase_q <= 1'b0;
            end
          end
        end
        S_IGNORE: ;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dio_o    = dout_q;
  assign dio_oe   = oe_q;
  assign qpi_mode = qpi_q;

endmodule

// File: tb/tb_psram_qpi_model.sv
// tb/tb_psram_qpi_model.sv - scoreboard bench for psram_qpi_model
`timescale 1ns/1ps

module tb_psram_qpi_model;

  localparam int MEM_AW    = 16;
  localparam int READ_WAIT = 6;
  localparam int SYNC_STG  = 2;
  localparam int HALF      = 50;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic       sck_t   = 1'b0;
  logic       ce_t    = 1'b1;
  logic [3:0] dio_t   = 4'd0;
  logic [3:0] dio_o;
  logic       dio_oe;
  logic       qpi_mode;

  psram_qpi_model #(
    .MEM_AW   (MEM_AW),
    .READ_WAIT(READ_WAIT),
    .SYNC_STG (SYNC_STG)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .sck     (sck_t),
    .ce_n    (ce_t),
    .dio_i   (dio_t),
    .dio_o   (dio_o),
    .dio_oe  (dio_oe),
    .qpi_mode(qpi_mode)
  );

  always #5 clock = ~clock;

  int         checks = 0;
  int         errors = 0;
  logic [3:0] exp_q[$];
  logic [3:0] wq[$];
  bit         rd_active = 1'b0;
  logic [7:0] ref_mem [int];
  bit         ref_qpi = 1'b0;
  bit         ref_rst_en = 1'b0;
  logic [3:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every controller sampling edge in a read data phase consumes one expected nibble
  always @(posedge sck_t) begin
    if (rd_active) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_extra: got %0h expected no data", dio_o);
      end else begin
        mon_e = exp_q.pop_front();
        check("rd_oe", dio_oe, 1);
        check("rd_nibble", dio_o, mon_e);
      end
    end
  end

  function automatic int wrap_addr(input logic [23:0] a, input int off);
    return (int'(a) + off) % (1 << MEM_AW);
  endfunction

  function automatic void model_cmd(input logic [7:0] c);
    if (c == 8'h66) begin
      ref_rst_en = 1'b1;
    end else begin
      if (c == 8'h35) ref_qpi = 1'b1;
      if (c == 8'hF5 && ref_qpi) ref_qpi = 1'b0;
      if (c == 8'h99 && ref_rst_en) ref_qpi = 1'b0;
      ref_rst_en = 1'b0;
    end
  endfunction

  task automatic nib(input logic [3:0] n);
    dio_t = n;
    #HALF sck_t = 1'b1;
    #HALF sck_t = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] c);
    if (ref_qpi) begin
      nib(c[7:4]);
      nib(c[3:0]);
    end else begin
      for (int i = 7; i >= 0; i--) nib({3'b000, c[i]});
    end
    model_cmd(c);
  endtask

  task automatic send_addr(input logic [23:0] a);
    for (int i = 5; i >= 0; i--) nib(a[4*i +: 4]);
  endtask

  task automatic end_frame();
    #HALF ce_t = 1'b1;
    dio_t = 4'd0;
    #(4*HALF);
  endtask

  task automatic push_byte(input logic [7:0] b);
    wq.push_back(b[7:4]);
    wq.push_back(b[3:0]);
  endtask

  task automatic cmd_frame(input logic [7:0] c);
    ce_t = 1'b0;
    #HALF;
    send_cmd(c);
    end_frame();
    check("qpi_mode", qpi_mode, ref_qpi);
  endtask

  // Write the nibbles queued in wq; only complete bytes reach the model
  task automatic do_write(input logic [23:0] a);
    ce_t = 1'b0;
    #HALF;
    send_cmd(8'h38);
    send_addr(a);
    for (int i = 0; i < wq.size(); i++) begin
      nib(wq[i]);
      if (i % 2 == 1) ref_mem[wrap_addr(a, i / 2)] = {wq[i-1], wq[i]};
    end
    wq.delete();
    end_frame();
  endtask

  // Read nnib nibbles; leaves the frame open for the caller to close or abort
  task automatic do_read(input logic [23:0] a, input int nnib);
    logic [7:0] b;
    ce_t = 1'b0;
    #HALF;
    send_cmd(8'hEB);
    send_addr(a);
    for (int i = 0; i < READ_WAIT; i++) begin
      dio_t = 4'd0;
      #HALF sck_t = 1'b1;
      if (i == READ_WAIT - 1) check("oe_at_last_dummy", dio_oe, 0);
      #HALF sck_t = 1'b0;
    end
    for (int i = 0; i < nnib; i++) begin
      b = ref_mem.exists(wrap_addr(a, i / 2)) ? ref_mem[wrap_addr(a, i / 2)] : 8'h00;
      exp_q.push_back((i % 2 == 0) ? b[7:4] : b[3:0]);
    end
    rd_active = 1'b1;
    for (int i = 0; i < nnib; i++) nib(4'd0);
    rd_active = 1'b0;
    check("rd_drain", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    logic [23:0] ra;
    int          n;

    #1;
    check("rst_oe", dio_oe, 0);
    check("rst_dout", dio_o, 0);
    check("rst_qpi", qpi_mode, 0);
    #99 reset_n = 1'b1;
    #(4*HALF);

    // Burst write then read back at 0x100
    push_byte(8'hDE); push_byte(8'hAD); push_byte(8'hBE); push_byte(8'hEF);
    do_write(24'h000100);
    do_read(24'h000100, 8);
    end_frame();

    // Partial byte is dropped; aborted read releases dio_oe quickly
    push_byte(8'h77); push_byte(8'h5A);
    do_write(24'h000010);
    wq.push_back(4'hA); wq.push_back(4'hB); wq.push_back(4'hC);
    do_write(24'h000010);
    do_read(24'h000010, 3);
    #HALF ce_t = 1'b1;
    repeat (SYNC_STG + 1) @(posedge clock);
    #1 check("oe_after_ce_high", dio_oe, 0);
    @(negedge clock);
    #(4*HALF);
    do_read(24'h000010, 4);
    end_frame();

    // Address wrap at the top of the array
    push_byte(8'h11); push_byte(8'h22);
    do_write(24'h00FFFF);
    do_read(24'h00FFFF, 4);
    end_frame();
    do_read(24'h000000, 2);
    end_frame();

    // Mode switching
    cmd_frame(8'hF5);
    cmd_frame(8'h35);
    do_read(24'h000100, 8);
    end_frame();
    cmd_frame(8'hF5);
    cmd_frame(8'hF5);

    // Reset-enable / reset pair
    cmd_frame(8'h35);
    cmd_frame(8'h66);
    cmd_frame(8'h99);
    cmd_frame(8'h35);
    cmd_frame(8'h66);
    do_read(24'h000101, 2);
    end_frame();
    cmd_frame(8'h99);

    // Randomised write/readback with occasional mode flips
    for (int it = 0; it < 16; it++) begin
      if ($urandom_range(0, 3) == 0) cmd_frame(ref_qpi ? 8'hF5 : 8'h35);
      ra = 24'($urandom());
      n  = $urandom_range(1, 5);
      for (int k = 0; k < n; k++) push_byte(8'($urandom()));
      do_write(ra);
      do_read(ra, 2 * n);
      end_frame();
    end

    // Reset in the middle of a QPI read; memory must survive
    if (!ref_qpi) cmd_frame(8'h35);
    do_read(24'h000100, 3);
    reset_n = 1'b0;
    #1;
    check("mid_reset_oe", dio_oe, 0);
    check("mid_reset_qpi", qpi_mode, 0);
    check("mid_reset_dout", dio_o, 0);
    ce_t = 1'b1;
    #19 reset_n = 1'b1;
    ref_qpi    = 1'b0;
    ref_rst_en = 1'b0;
    #(4*HALF);
    ref_mem[32'h100] = 8'hDE; ref_mem[32'h101] = 8'hAD;
    ref_mem[32'h102] = 8'hBE; ref_mem[32'h103] = 8'hEF;
    do_read(24'h000100, 8);
    end_frame();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
